ex_alu_stage: RTL
=================

Name: ex_alu_stage

Overview:
- Execute stage of the 16-bit MIPS pipeline.
- Consumes operand A from the register-read path and operand B from the immediate/register select mux. Operand B is a 16-bit immediate, or a zero-extended 3-bit shift/register field.
- Performs the ALU operation and registers the result, destination and write-enable toward the EX/MEM boundary.
- Single-cycle ops have 1-cycle latency. MUL runs on an iterative shift-add engine and stalls upstream while busy.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- REG_AW, 3, destination register address width.
- MUL_CYCLES, 16, iterations of the multiply engine; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decoded instruction present on inputs.
- in_ready  out  1  stage can accept an instruction this cycle.
- alu_op  in  4  operation code (see Behaviour).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B, from the immediate/register select mux.
- dest_in  in  REG_AW  destination register.
- wen_in  in  1  register write enable of the instruction.
- flush  in  1  branch/jump squash of the EX stage.
- stall  in  1  downstream cannot accept the output register.
- out_valid  out  1  result register holds a live instruction.
- result  out  WIDTH  registered ALU result.
- dest_out  out  REG_AW  registered destination.
- wen_out  out  1  registered write enable, forced 0 when out_valid=0.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow of ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (async, any time, including mid-multiply): out_valid=0, result=0, dest_out=0, wen_out=0, zero=1, ovf=0, engine idle.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLT: signed compare, result 1 or 0.
  - 7 SLL; 8 SRL; 9 SRA: shift amount op_b[3:0].
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11 LUI: op_b << 8.
  - 12-15: result 0, ovf 0.
- Accept condition: in_valid && in_ready && !flush.
- in_ready = !busy && (!out_valid || !stall).
- Single-cycle op accepted at edge N: result, dest_out, wen_out, zero, ovf and out_valid=1 are all visible after edge N.
- MUL accepted at edge N:
  - busy=1 and in_ready=0 from N through N+15.
  - The engine adds the shifted multiplicand when the multiplier LSB is 1, one bit per cycle, for MUL_CYCLES cycles.
  - The result register loads at edge N+16 with out_valid=1.
  - While busy, out_valid=0 unless a prior result is still held by stall.
- Engine completes while stall=1 and out_valid=1: the engine holds its final value, and loads at the first edge where stall=0.
- stall=1 with out_valid=1: all output registers hold unchanged.
- flush (priority over everything except rst):
  - Clears out_valid and wen_out and aborts any multiply (busy=0 next cycle).
  - An in_valid presented in the same cycle is dropped.
  - Flush takes effect even if stall=1.
- Arithmetic wraps modulo 2^WIDTH.
- ovf for ADD: operands have equal signs and the result sign differs.
- ovf for SUB: operand signs differ and the result sign differs from op_a.
- zero is computed from the registered result value.
- Output stays valid until consumed. out_valid drops to 0 at the next edge with stall=0 if no new instruction is accepted.

Decomposition:
- Shared package/include holds:
  - ALU opcode constants (ALU_ADD..ALU_LUI).
  - WIDTH and REG_AW defaults.
- One sub-module: mul_iter. It owns the shift-add datapath and the cycle counter, with ports start / done / product.
- The top holds the combinational ALU, the output register and the handshake.

Test Plan:
- ADD 0x7FFF+0x0001, dest 3, wen 1 -> next cycle result=0x8000, ovf=1, zero=0, out_valid=1, dest_out=3.
- SUB 0x0005-0x0005 -> result=0x0000, zero=1, ovf=0. SRA 0x8000 by op_b=3 -> 0xF000. LUI op_b=0x00AB -> 0xAB00.
- MUL 0x0012*0x0034 -> in_ready=0 for 16 cycles, then result=0x03A8 with out_valid=1. A back-to-back ADD is held off until in_ready returns.
- stall=1 for 3 cycles with out_valid=1 -> result, dest_out and wen_out are unchanged. in_ready=0 throughout; a new op is accepted on the first cycle with stall=0.
- flush asserted 5 cycles into a MUL, with in_valid=1 in the same cycle -> engine idle next cycle, out_valid=0, wen_out=0, no result ever emitted, input dropped.
- rst pulsed mid-MUL, asynchronously between edges -> outputs immediately take their reset values, busy=0, in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/ex_alu_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_alu_stage_pkg
// Shared definitions for the EX stage of the 16-bit MIPS pipeline:
//   - default datapath / register-address widths
//   - ALU opcode constants (ALU_ADD .. ALU_LUI; codes 12-15 are unused)
//   - multiply engine state encoding (exported for debug/checkers)
// ---------------------------------------------------------------------------
package ex_alu_stage_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_LUI = 4'd11;

  // MUL_HOLD: product finished but the output register is stalled.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_HOLD = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_alu_stage_mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load operands and begin (only honoured when idle)
//   abort           squash the operation, return to idle next cycle
//   ack             consumer takes the product this cycle (while done=1)
//   mcand_in        multiplicand (operand A)
//   mplier_in       multiplier   (operand B)
//   state           current engine state (busy = state != MUL_IDLE)
//   done            product is valid this cycle
//   product         low WIDTH bits of the unsigned product
// The last iteration's sum is presented combinationally so the consumer can
// register it on the same edge the iteration would complete; MUL_CYCLES
// iterations therefore occupy exactly MUL_CYCLES cycles after start.
// ---------------------------------------------------------------------------
module mul_iter
  import ex_alu_stage_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output mul_state_e       state,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] step_sum;
  logic             last_step;

  assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = (count_q == CW'(MUL_CYCLES - 1));
  assign state     = state_q;
  assign done      = ((state_q == MUL_RUN) && last_step) || (state_q == MUL_HOLD);
  assign product   = (state_q == MUL_HOLD) ? acc_q : step_sum;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          mcand_d  = mcand_in;
          mplier_d = mplier_in;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Final sum is parked in acc_q when the consumer cannot take it.
        if (last_step) state_d = ack ? MUL_IDLE : MUL_HOLD;
      end
      MUL_HOLD: begin
        if (ack) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
    if (abort) state_d = MUL_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage
// Execute stage: combinational ALU, iterative MUL, EX/MEM output register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   instruction handshake; accepted when
//                       in_valid && in_ready && !flush
//   alu_op, op_a, op_b  operation and operands
//   dest_in, wen_in     destination register and its write enable
//   flush               squash: clears output valid, aborts MUL, drops input
//   stall               downstream holds the output register
//   out_valid, result, dest_out, wen_out, zero, ovf   registered outputs
// Handshake: in_ready = !busy && (!out_valid || !stall). An output stays
// valid until a cycle with stall=0 consumes it; flush overrides stall.
// ---------------------------------------------------------------------------
module ex_alu_stage
  import ex_alu_stage_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MUL_CYCLES = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              wen_in,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic [REG_AW-1:0] dest_out,
  output logic              wen_out,
  output logic              zero,
  output logic              ovf
);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              wen_q, wen_d;
  logic              ovf_q, ovf_d;
  logic [REG_AW-1:0] mul_dest_q, mul_dest_d;
  logic              mul_wen_q, mul_wen_d;

  logic [WIDTH-1:0]  alu_res, sum, diff;
  logic              alu_ovf;
  logic [3:0]        shamt;
  logic              busy, accept, out_hold, mul_start, mul_ack, mul_done;
  logic [WIDTH-1:0]  mul_product;
  mul_state_e        mul_state;

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_b[3:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_LUI: alu_res = op_b << 8;
      default: alu_res = '0;
    endcase
  end

  assign busy      = (mul_state != MUL_IDLE);
  assign out_hold  = valid_q && stall;
  assign in_ready  = !busy && !out_hold;
  assign accept    = in_valid && in_ready && !flush;
  assign mul_start = accept && (alu_op == ALU_MUL);
  assign mul_ack   = mul_done && !out_hold && !flush;

  mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .abort     (flush),
    .ack       (mul_ack),
    .mcand_in  (op_a),
    .mplier_in (op_b),
    .state     (mul_state),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    dest_d     = dest_q;
    wen_d      = wen_q;
    ovf_d      = ovf_q;
    mul_dest_d = mul_dest_q;
    mul_wen_d  = mul_wen_q;
    // MUL destination travels alongside the engine until it completes.
    if (mul_start) begin
      mul_dest_d = dest_in;
      mul_wen_d  = wen_in;
    end
    if (flush) begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
    end else if (out_hold) begin
      // everything holds
    end else if (mul_ack) begin
      valid_d  = 1'b1;
      result_d = mul_product;
      dest_d   = mul_dest_q;
      wen_d    = mul_wen_q;
      ovf_d    = 1'b0;
    end else if (accept && (alu_op != ALU_MUL)) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      dest_d   = dest_in;
      wen_d    = wen_in;
      ovf_d    = alu_ovf;
    end else begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      dest_q     <= '0;
      wen_q      <= 1'b0;
      ovf_q      <= 1'b0;
      mul_dest_q <= '0;
      mul_wen_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      dest_q     <= dest_d;
      wen_q      <= wen_d;
      ovf_q      <= ovf_d;
      mul_dest_q <= mul_dest_d;
      mul_wen_q  <= mul_wen_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign dest_out  = dest_q;
  assign wen_out   = wen_q & valid_q;
  assign zero      = (result_q == '0);
  assign ovf       = ovf_q;

endmodule
